// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board-level types and constants
//
// Purpose: state encoding for the per-channel debounce FSM and board clock
//          constants shared by the input-conditioning blocks.
// Ports:   none (package)

package board_pkg;

    localparam int CLK_HZ = 100000000;

    // 10 ms at CLK_HZ
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    typedef enum logic [1:0] {
        STABLE_0 = 2'd0,
        WAIT_1   = 2'd1,
        STABLE_1 = 2'd2,
        WAIT_0   = 2'd3
    } db_state_t;

endpackage

// File: rtl/button_debouncer_channel.sv
// rtl/button_debouncer_channel.sv - single-bit synchronizer and debounce FSM
//
// Purpose: brings one raw button pin into the clk domain and accepts a new
//          level only after it has been stable for DEBOUNCE_CYCLES+1 cycles.
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   btn_raw     asynchronous raw pin, active-high
//   btn_level   debounced level (registered)
//   btn_press   one-cycle pulse on accepted 0->1
//   btn_release one-cycle pulse on accepted 1->0

module button_debouncer_channel
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= STABLE_0;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

    // The counter is cleared on every WAIT_* entry, so it never reaches
    // beyond CNT_LAST and cannot wrap.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        unique case (state)
            STABLE_0: begin
                if (s2) begin
                    state_nxt = WAIT_1;
                    cnt_nxt   = '0;
                end
            end
            WAIT_1: begin
                if (!s2) begin
                    state_nxt = STABLE_0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_1;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STABLE_1: begin
                if (!s2) begin
                    state_nxt = WAIT_0;
                    cnt_nxt   = '0;
                end
            end
            WAIT_0: begin
                if (s2) begin
                    state_nxt = STABLE_1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = STABLE_0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = STABLE_0;
        endcase
    end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel push-button debouncer
//
// Purpose: WIDTH independent debounce channels for raw board buttons; level
//          outputs feed the gate exercises (btn_level[0] -> a, [1] -> b).
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   btn_raw     [WIDTH] asynchronous raw pins, active-high
//   btn_level   [WIDTH] debounced levels
//   btn_press   [WIDTH] one-cycle accepted-press pulses
//   btn_release [WIDTH] one-cycle accepted-release pulses

module button_debouncer
    import board_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        button_debouncer_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer

module tb_button_debouncer;

    localparam int W = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] btn_raw;
    logic [W-1:0] btn_level;
    logic [W-1:0] btn_press;
    logic [W-1:0] btn_release;

    int n_cmp  = 0;
    int n_fail = 0;

    button_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Reference: the FSM sees the raw pin two edges late; a new level is
    // accepted once the delayed value has held for D+1 consecutive edges.
    logic         md1[W];
    logic         md2[W];
    int           mrun[W];
    logic         mval[W];
    logic [W-1:0] mlevel;
    logic [W-1:0] mpress;
    logic [W-1:0] mrel;

    task automatic step(input logic [W-1:0] raw, input logic rstn);
        logic x;
        btn_raw = raw;
        rst_n   = rstn;
        @(posedge clk);
        mpress = '0;
        mrel   = '0;
        if (!rstn) begin
            mlevel = '0;
            for (int c = 0; c < W; c++) begin
                md1[c] = 1'b0; md2[c] = 1'b0; mrun[c] = 0; mval[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < W; c++) begin
                x      = md2[c];
                md2[c] = md1[c];
                md1[c] = raw[c];
                if (x == mval[c]) mrun[c]++;
                else begin mval[c] = x; mrun[c] = 1; end
                if (mrun[c] >= D + 1 && mval[c] != mlevel[c]) begin
                    mlevel[c] = mval[c];
                    if (mval[c]) mpress[c] = 1'b1;
                    else         mrel[c]   = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            step('0, 1'b0);
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d got=%b want=000000", k, {btn_level, btn_press, btn_release});
            end
        end
        for (int k = 0; k < 20; k++) begin
            step('0, 1'b1);
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d got=%b want=000000", k, {btn_level, btn_press, btn_release});
            end
        end
    endtask

    task automatic settle(input string tag);
        for (int k = 0; k < 12; k++) begin
            step('0, 1'b1);
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== {mlevel, mpress, mrel}) begin
                n_fail++;
                $display("FAIL %s_settle k=%0d got=%b want=%b", tag, k, {btn_level, btn_press, btn_release}, {mlevel, mpress, mrel});
            end
        end
    endtask

    task automatic test_single_press;
        logic [W-1:0] el, ep;
        for (int k = 0; k < 10; k++) begin
            step(2'b01, 1'b1);
            el = (k >= 6) ? 2'b01 : 2'b00;
            ep = (k == 6) ? 2'b01 : 2'b00;
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== {el, ep, 2'b00}) begin
                n_fail++;
                $display("FAIL single_press k=%0d got=%b want=%b", k, {btn_level, btn_press, btn_release}, {el, ep, 2'b00});
            end
        end
        settle("single");
    endtask

    task automatic test_min_pulse;
        logic [W-1:0] el, ep, er;
        for (int k = 0; k < 16; k++) begin
            step((k < 4) ? 2'b01 : 2'b00, 1'b1);
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== 6'b0) begin
                n_fail++;
                $display("FAIL short_pulse k=%0d got=%b want=000000", k, {btn_level, btn_press, btn_release});
            end
        end
        for (int k = 0; k < 16; k++) begin
            step((k < 5) ? 2'b01 : 2'b00, 1'b1);
            el = (k >= 6 && k < 11) ? 2'b01 : 2'b00;
            ep = (k == 6)  ? 2'b01 : 2'b00;
            er = (k == 11) ? 2'b01 : 2'b00;
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== {el, ep, er}) begin
                n_fail++;
                $display("FAIL min_pulse k=%0d got=%b want=%b", k, {btn_level, btn_press, btn_release}, {el, ep, er});
            end
        end
    endtask

    task automatic test_bounce;
        int pat[10] = '{1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
        logic [W-1:0] el, ep;
        logic b;
        for (int k = 0; k < 16; k++) begin
            b = (k < 10) ? pat[k][0] : 1'b1;
            step({b, 1'b0}, 1'b1);
            el = (k >= 11) ? 2'b10 : 2'b00;
            ep = (k == 11) ? 2'b10 : 2'b00;
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== {el, ep, 2'b00}) begin
                n_fail++;
                $display("FAIL bounce k=%0d got=%b want=%b", k, {btn_level, btn_press, btn_release}, {el, ep, 2'b00});
            end
        end
        settle("bounce");
    endtask

    task automatic test_simultaneous;
        logic [W-1:0] el, ep, er;
        for (int k = 0; k < 10; k++) begin
            step(2'b11, 1'b1);
            el = (k >= 6) ? 2'b11 : 2'b00;
            ep = (k == 6) ? 2'b11 : 2'b00;
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== {el, ep, 2'b00}) begin
                n_fail++;
                $display("FAIL simul_press k=%0d got=%b want=%b", k, {btn_level, btn_press, btn_release}, {el, ep, 2'b00});
            end
        end
        for (int k = 0; k < 10; k++) begin
            step(2'b00, 1'b1);
            el = (k >= 6) ? 2'b00 : 2'b11;
            er = (k == 6) ? 2'b11 : 2'b00;
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== {el, 2'b00, er}) begin
                n_fail++;
                $display("FAIL simul_release k=%0d got=%b want=%b", k, {btn_level, btn_press, btn_release}, {el, 2'b00, er});
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] el, ep;
        // Edges 0..4 put channel 0 in WAIT_1 with cnt=2; reset at edge 5;
        // edge 6 is the first post-reset sample, so the press lands on 12.
        for (int k = 0; k < 16; k++) begin
            step(2'b01, (k != 5));
            el = (k >= 12) ? 2'b01 : 2'b00;
            ep = (k == 12) ? 2'b01 : 2'b00;
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== {el, ep, 2'b00}) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d got=%b want=%b", k, {btn_level, btn_press, btn_release}, {el, ep, 2'b00});
            end
        end
        settle("reset_mid");
    endtask

    task automatic test_random;
        logic [W-1:0] raw = '0;
        int hold[W];
        logic rstn;
        for (int c = 0; c < W; c++) hold[c] = 0;
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < W; c++) begin
                if (hold[c] == 0) begin
                    raw[c]  = ~raw[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 6);
                end
                hold[c]--;
            end
            rstn = ($urandom_range(0, 249) != 0);
            step(raw, rstn);
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== {mlevel, mpress, mrel}) begin
                n_fail++;
                $display("FAIL random k=%0d raw=%b got=%b want=%b", k, raw, {btn_level, btn_press, btn_release}, {mlevel, mpress, mrel});
            end
        end
        settle("random");
    endtask

    initial begin
        btn_raw = '0;
        rst_n   = 1'b0;
        mlevel  = '0;
        mpress  = '0;
        mrel    = '0;
        for (int c = 0; c < W; c++) begin
            md1[c] = 1'b0; md2[c] = 1'b0; mrun[c] = 0; mval[c] = 1'b0;
        end
        #2;
        test_reset();
        test_single_press();
        test_min_pulse();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Cleans raw push-button inputs from the board pins before they reach the combinational gate exercises (operands `a`/`b`) and later counter and FSM exercises.
- Per channel: 2-flop synchronizer, then a stability-counter FSM.
- Outputs per channel: a debounced level, a one-cycle press pulse and a one-cycle release pulse.
- Directly upstream of the gates stage: `btn_level[0]` drives `a`, `btn_level[1]` drives `b`.

Parameters:
- `WIDTH`, 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, 1000000: clock cycles a synchronized input must stay stable before it is accepted. This is 10 ms at 100 MHz. Legal range is ≥1; benches override it with 4.

Ports:
- `clk` input 1: system clock, 100 MHz on board.
- `rst_n` input 1: synchronous, active-low reset.
- `btn_raw` input `WIDTH`: asynchronous raw button pins, active-high.
- `btn_level` output `WIDTH`: debounced button state.
- `btn_press` output `WIDTH`: one-cycle pulse on accepted 0→1.
- `btn_release` output `WIDTH`: one-cycle pulse on accepted 1→0.

Behaviour:
- **Interface:** one clock; reset is synchronous and active-low. The clock port is `clk` and the reset port is `rst_n`. All flops update on the rising edge of `clk`. No asynchronous reset anywhere.
- **Reset** (`rst_n`=0 at a rising edge):
  - sync flops, state and counter are cleared;
  - state goes to `STABLE_0`;
  - `btn_level`, `btn_press` and `btn_release` are all 0 after that edge.
- **Reset mid-operation:** reset applied in any state drops `btn_level` to 0 without a release pulse and discards partial counts.
- **Synchronizer:** `s1` <= `btn_raw`; `s2` <= `s1`. The FSM sees only `s2`.
- **Counter:** `cnt` is `$clog2(DEBOUNCE_CYCLES)`+1 bits, unsigned. It never wraps, because it is cleared on every state entry.
- **FSM states (per channel):**
  - `STABLE_0`: if `s2`=1, go to `WAIT_1` and set `cnt`=0. Else stay.
  - `WAIT_1`:
    - if `s2`=0, return to `STABLE_0` (bounce rejected, no pulse);
    - else if `cnt`==`DEBOUNCE_CYCLES`-1, go to `STABLE_1`, set `btn_level`=1 and `btn_press`=1;
    - else `cnt`++.
  - `STABLE_1`: if `s2`=0, go to `WAIT_0` and set `cnt`=0. Else stay.
  - `WAIT_0`: mirror of `WAIT_1`. `s2`=1 returns to `STABLE_1`. The terminal count goes to `STABLE_0` with `btn_level`=0 and `btn_release`=1.
- **`btn_level`:** registered, equal to 1 in `STABLE_1` and `WAIT_0`. It holds its old value while in `WAIT_*`.
- **Pulses:** `btn_press` and `btn_release` are registered. Each is high for exactly one cycle, starting the edge the level changes. They are never both high on one channel, and never repeat while the level is held.
- **Latency:** let edge 0 be the first edge that samples the new raw value. `btn_level` and the pulse change at edge `DEBOUNCE_CYCLES`+2.
- **Minimum accepted pulse:** raw must be stable for ≥`DEBOUNCE_CYCLES`+1 consecutive sampled cycles. Shorter excursions are filtered completely.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels are processed in parallel with identical timing.
- **Held button at reset:** if a button is held while reset is released, it is debounced from `STABLE_0` as a normal press. A press pulse at edge `DEBOUNCE_CYCLES`+2 is the required behaviour.

Decomposition:
- **Shared package** `board_pkg`:
  - 2-bit state type with constants `STABLE_0`=0, `WAIT_1`=1, `STABLE_1`=2, `WAIT_0`=3;
  - `CLK_HZ`=100000000;
  - default debounce constant.
- **Sub-module** `button_debouncer_channel`: one bit holding sync, counter and FSM. The top instantiates `WIDTH` copies in a generate loop.

Test Plan (`DEBOUNCE_CYCLES`=4, `WIDTH`=2):
1. Hold `rst_n`=0 for 3 cycles, then release with `btn_raw`=00 for 20 cycles → all outputs stay 00 throughout.
2. Set `btn_raw[0]` 0→1 held, first sampled at edge 0 →
   - `btn_level[0]` rises at edge 6;
   - `btn_press[0]`=1 only during cycle 6–7;
   - `btn_release`=00;
   - channel 1 stays 0.
3. Drive `btn_raw[0]` high for 4 sampled cycles, then low → no change on any output. Repeat with 5 cycles → exactly one press pulse at edge 6, then a release pulse at edge 11.
4. Bounce pattern 1,1,0,1,0,1,1,1,1,1 on `btn_raw[1]` → exactly one `btn_press[1]` pulse, 6 edges after the final 0→1 sample. `btn_level[1]` never toggles before it.
5. Drive both channels 0→1 on the same edge → `btn_level`=11 and `btn_press`=11 on the same edge 6. Then both go 1→0 → `btn_release`=11 on one cycle, `btn_level`=00.
6. With channel 0 in `WAIT_1` at `cnt`=2, drive `rst_n`=0 for one edge →
   - outputs become 00 on that edge, with no pulses;
   - `btn_raw[0]` stays 1 after `rst_n` returns high;
   - press pulse 6 edges after the first post-reset sample.
